// File: rtl/gsc_ctrl.sv
// gsc_ctrl: green-screen keyer control with debounced buttons, a frame-synchronous enable FSM and threshold.
// Build option: define GSC_STATS_EN to add the per-frame key-pixel counter (key_count/count_valid).
module gsc_ctrl #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter logic [24:0] THR_INIT   = 25'h00143DA,
  parameter logic [24:0] THR_STEP   = 25'h0001000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_toggle_n,
  input  logic               btn_up_n,
  input  logic               btn_dn_n,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic               key_hit,
  output logic               gsc_en,
  output logic signed [24:0] thresh,
  output logic [1:0]         state,
  output logic [19:0]        key_count,
  output logic               count_valid
);

  localparam logic [24:0] THR_MAX = 25'h0FFFFFF;

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_ARM_ON  = 2'd1,
    S_ON      = 2'd2,
    S_ARM_OFF = 2'd3
  } state_t;

  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       level_q, level_d;
  logic [2:0]       press_q, press_d;
  logic [2:0][19:0] deb_cnt_q, deb_cnt_d;
  logic [24:0]      shadow_q, shadow_d;
  logic [24:0]      thresh_q, thresh_d;
  logic             toggle_p, up_p, dn_p;
  state_t           state_q;
  logic             gsc_en_q;

  assign btn_raw  = {btn_dn_n, btn_up_n, btn_toggle_n};
  assign toggle_p = press_q[0];
  assign up_p     = press_q[1];
  assign dn_p     = press_q[2];

  // Debounced level resets to "pressed" so a button held through reset must be released before it can fire.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = '0;
    deb_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_CYCLES - 20'd1) begin
          level_d[i] = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 20'd1;
        end
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (up_p && !dn_p) begin
      shadow_d = (shadow_q > THR_MAX - THR_STEP) ? THR_MAX : shadow_q + THR_STEP;
    end else if (dn_p && !up_p) begin
      shadow_d = (shadow_q < THR_STEP) ? 25'd0 : shadow_q - THR_STEP;
    end
    thresh_d = frame_start ? shadow_q : thresh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      deb_cnt_q <= '0;
      shadow_q  <= THR_INIT;
      thresh_q  <= THR_INIT;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
      shadow_q  <= shadow_d;
      thresh_q  <= thresh_d;
    end
  end

  // A toggle landing on frame_start is a fresh request, so the armed state flips rather than settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      gsc_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (toggle_p) state_q <= S_ARM_ON;
        end
        S_ARM_ON: begin
          if (frame_start && toggle_p) begin
            state_q  <= S_ARM_OFF;
            gsc_en_q <= 1'b1;
          end else if (frame_start) begin
            state_q  <= S_ON;
            gsc_en_q <= 1'b1;
          end else if (toggle_p) begin
            state_q <= S_OFF;
          end
        end
        S_ON: begin
          if (toggle_p) state_q <= S_ARM_OFF;
        end
        default: begin
          if (frame_start && toggle_p) begin
            state_q  <= S_ARM_ON;
            gsc_en_q <= 1'b0;
          end else if (frame_start) begin
            state_q  <= S_OFF;
            gsc_en_q <= 1'b0;
          end else if (toggle_p) begin
            state_q <= S_ON;
          end
        end
      endcase
    end
  end

  assign gsc_en = gsc_en_q;
  assign thresh = $signed(thresh_q);
  assign state  = state_q;

`ifdef GSC_STATS_EN
  logic [19:0] hit_cnt_q, hit_cnt_d;
  logic [19:0] key_count_q, key_count_d;
  logic        count_valid_q, count_valid_d;
  logic        hit;

  // A hit on the frame_start cycle belongs to the frame that is just beginning.
  always_comb begin
    hit           = pix_valid & key_hit;
    hit_cnt_d     = hit_cnt_q;
    key_count_d   = key_count_q;
    count_valid_d = 1'b0;
    if (frame_start) begin
      key_count_d   = hit_cnt_q;
      count_valid_d = 1'b1;
      hit_cnt_d     = {19'd0, hit};
    end else if (hit && hit_cnt_q != 20'hFFFFF) begin
      hit_cnt_d = hit_cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q     <= '0;
      key_count_q   <= '0;
      count_valid_q <= 1'b0;
    end else begin
      hit_cnt_q     <= hit_cnt_d;
      key_count_q   <= key_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign key_count   = key_count_q;
  assign count_valid = count_valid_q;
`else
  logic unused_stats_inputs;
  assign unused_stats_inputs = pix_valid ^ key_hit;
  assign key_count   = '0;
  assign count_valid = 1'b0;
`endif

endmodule
